sr_latch_ctrl: RTL and testbench



---
 rtl/sr_ctrl_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 42 ++++
 rtl/sr_latch_ctrl.sv | 144 ++++++++++++++
 tb/tb_sr_latch_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/sr_ctrl_pkg.sv
`default_nettype none
// ============================================================
// Module  : sr_ctrl_pkg
// Brief   : Shared state and op encodings for the SR latch sequencer.
// Revision: 1.0
// ============================================================
package sr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam logic OP_SET   = 1'b1;
    localparam logic OP_RESET = 1'b0;

endpackage : sr_ctrl_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================
// Module  : rr_arbiter
// Brief   : Combinational pick of the first eligible bit at or above ptr, wrapping.
// Revision: 1.0
// ============================================================
module rr_arbiter
    import sr_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         eligible_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] grant_idx_o,
    output logic                 valid_o
);

    localparam int IW = $clog2(N);

    int   k;
    logic found;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        valid_o     = 1'b0;
        found       = 1'b0;
        k           = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr_i) + i) % N;
            if (!found && eligible_i[IW'(k)]) begin
                found              = 1'b1;
                valid_o            = 1'b1;
                grant_idx_o        = IW'(k);
                grant_o[IW'(k)]    = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/sr_latch_ctrl.sv
`default_nettype none
// ============================================================
// Module  : sr_latch_ctrl
// Brief   : Round-robin sequencer driving exclusive s/r pulses into a shared SR latch.
// Revision: 1.0
// ============================================================
module sr_latch_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] op_i,
    output logic [N_REQ-1:0] ack_o,
    output logic             s_o,
    output logic             r_o,
    input  logic             q_i,
    output logic             busy_o,
    output logic             err_o
);

    localparam int MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int IDX_W   = $clog2(N_REQ);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               op_l_q, op_l_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               s_q, s_d;
    logic               r_q, r_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic [N_REQ-1:0]   eligible;
    logic [N_REQ-1:0]   grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;

    // The requester being acked is still holding req this cycle; keep it out.
    assign eligible = req_i & ~ack_q;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .eligible_i  (eligible),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .valid_o     (grant_valid)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        rr_ptr_d = rr_ptr_q;
        op_l_d   = op_l_q;
        err_d    = err_q;
        ack_d    = '0;
        s_d      = 1'b0;
        r_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    idx_d   = grant_idx;
                    op_l_d  = |(op_i & grant);
                    cnt_d   = CNT_W'(PULSE_CYC - 1);
                    state_d = PULSE;
                    s_d     = (op_l_d == OP_SET);
                    r_d     = (op_l_d == OP_RESET);
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(GAP_CYC - 1);
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    s_d   = (op_l_q == OP_SET);
                    r_d   = (op_l_q == OP_RESET);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    if (q_i != op_l_q) begin
                        err_d = 1'b1;
                    end
                    ack_d[idx_q] = 1'b1;
                    rr_ptr_d     = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            rr_ptr_q <= '0;
            op_l_q   <= 1'b0;
            ack_q    <= '0;
            s_q      <= 1'b0;
            r_q      <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
            op_l_q   <= op_l_d;
            ack_q    <= ack_d;
            s_q      <= s_d;
            r_q      <= r_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign ack_o  = ack_q;
    assign s_o    = s_q;
    assign r_o    = r_q;
    assign busy_o = busy_q;
    assign err_o  = err_q;

endmodule : sr_latch_ctrl
`default_nettype wire

// File: tb/tb_sr_latch_ctrl.sv
`default_nettype none
// ============================================================
// Module  : tb_sr_latch_ctrl
// Brief   : Randomized requesters and SR latch model against an operation-timeline reference.
// Revision: 1.0
// ============================================================
module tb_sr_latch_ctrl;

    localparam int N = 4;
    localparam int P = 2;
    localparam int G = 1;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req   = '0;
    logic [N-1:0] op    = '0;
    logic [N-1:0] ack;
    logic         s, r, busy, err;
    logic         q_lat = 1'b0;
    logic         stuck = 1'b0;
    logic         q;

    assign q = stuck ? 1'b0 : q_lat;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (s)      q_lat <= 1'b1;
        else if (r) q_lat <= 1'b0;
    end

    sr_latch_ctrl #(
        .N_REQ     (N),
        .PULSE_CYC (P),
        .GAP_CYC   (G)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_i  (req),
        .op_i   (op),
        .ack_o  (ack),
        .s_o    (s),
        .r_o    (r),
        .q_i    (q),
        .busy_o (busy),
        .err_o  (err)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Reference: at most one operation in flight, described by its grant cycle.
    bit active = 1'b0;
    int g      = 0;
    int m_idx  = 0;
    bit m_op   = 1'b0;
    int m_ptr  = 0;
    bit m_err  = 1'b0;
    bit in_rst = 1'b1;
    int wait_ops [N];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    endtask

    task automatic tick(input bit do_rst, input bit do_rel, input logic [N-1:0] mask, input int persist);
        int           off;
        bit           s_x, r_x, busy_x, found;
        logic [N-1:0] ack_x, elig;
        @(negedge clk);
        cyc++;
        off    = active ? (cyc - g) : -1;
        s_x    = active && off >= 1 && off <= P && m_op;
        r_x    = active && off >= 1 && off <= P && !m_op;
        busy_x = active && off >= 1 && off <= P + G;
        ack_x  = (active && off == P + G + 1) ? (N'(1) << m_idx) : '0;

        check_value("s",       32'(s),     32'(s_x));
        check_value("r",       32'(r),     32'(r_x));
        check_value("busy",    32'(busy),  32'(busy_x));
        check_value("ack",     32'(ack),   32'(ack_x));
        check_value("err",     32'(err),   32'(m_err));
        check_value("s_and_r", 32'(s & r), 32'(0));

        if (active && off == P + G + 1) active = 1'b0;

        for (int i = 0; i < N; i++) begin
            if (ack_x[i]) begin
                if ($urandom_range(99) < persist) begin
                    op[i]       = 1'($urandom_range(1));
                    wait_ops[i] = 0;
                end else begin
                    req[i] = 1'b0;
                end
            end else if (!req[i] && mask[i] && $urandom_range(3) == 0) begin
                req[i]      = 1'b1;
                op[i]       = 1'($urandom_range(1));
                wait_ops[i] = 0;
            end
        end

        if (do_rst) begin
            rst_n = 1'b0;
            #1;
            check_value("rst_async_s",   32'(s),   32'(0));
            check_value("rst_async_r",   32'(r),   32'(0));
            check_value("rst_async_ack", 32'(ack), 32'(0));
            in_rst = 1'b1;
            active = 1'b0;
            m_ptr  = 0;
            m_err  = 1'b0;
            for (int i = 0; i < N; i++) wait_ops[i] = 0;
        end
        if (do_rel) begin
            rst_n  = 1'b1;
            in_rst = 1'b0;
        end

        if (!in_rst && active && off == P + G) begin
            if (q != m_op) m_err = 1'b1;
            m_ptr = (m_idx + 1) % N;
        end

        if (!in_rst && !active) begin
            elig  = req & ~ack_x;
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                int j = (m_ptr + k) % N;
                if (!found && elig[j]) begin
                    found = 1'b1;
                    check_value("rr_wait_bound", 32'(wait_ops[j] <= N - 1), 32'(1));
                    for (int i = 0; i < N; i++)
                        if (i != j && elig[i]) wait_ops[i]++;
                    active = 1'b1;
                    g      = cyc;
                    m_idx  = j;
                    m_op   = op[j];
                end
            end
        end
    endtask

    task automatic run(input int n, input logic [N-1:0] mask, input int persist);
        for (int t = 0; t < n; t++) tick(1'b0, 1'b0, mask, persist);
    endtask

    initial begin
        bit hit;
        for (int i = 0; i < N; i++) wait_ops[i] = 0;

        tick(1'b0, 1'b0, '0, 0);
        tick(1'b0, 1'b0, '0, 0);
        tick(1'b0, 1'b1, '0, 0);

        run(30, 4'b0001, 0);
        run(30, 4'b0010, 0);
        run(60, 4'b1111, 100);
        run(40, 4'b0100, 100);

        stuck = 1'b1;
        run(80, 4'b1111, 30);
        check_value("err_after_stuck", 32'(err), 32'(1));
        stuck = 1'b0;
        run(80, 4'b1111, 30);
        check_value("err_sticky", 32'(err), 32'(1));
        tick(1'b1, 1'b0, 4'b1111, 30);
        tick(1'b0, 1'b0, 4'b1111, 30);
        tick(1'b0, 1'b1, 4'b1111, 30);
        check_value("err_cleared", 32'(err), 32'(0));

        hit = 1'b0;
        for (int t = 0; t < 300 && !hit; t++) begin
            if (active && (cyc + 1 - g) == 2) hit = 1'b1;
            else tick(1'b0, 1'b0, 4'b1111, 100);
        end
        check_value("mid_pulse_reached", 32'(hit), 32'(1));
        tick(1'b1, 1'b0, 4'b1111, 100);
        tick(1'b0, 1'b0, 4'b1111, 100);
        tick(1'b0, 1'b1, 4'b1111, 100);
        run(100, 4'b1111, 25);

        run(300, 4'b1111, 25);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_sr_latch_ctrl
`default_nettype wire
